// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the twiddle-factor streamer.
// The quarter-wave table is computed from real math at elaboration and never at run time.
package twiddle_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int log2_int(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Ties go away from zero, so the table is symmetric under negation.
    function automatic int round_half_away(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
    endfunction

    function automatic int quarter_entry(input int i, input int n, input int dw);
        real a;
        a = real'((1 << (dw - 1)) - 1);
        return round_half_away(a * $cos(2.0 * PI * real'(i) / real'(n)));
    endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Dual-read quarter-wave cosine table, T[0..N/4], registered read with clock enable.
module twiddle_quarter_rom
    import twiddle_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int DATA_W   = 8,
    parameter int AW       = 3
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [AW-1:0]            addr_a,
    input  logic [AW-1:0]            addr_b,
    output logic signed [DATA_W-1:0] dout_a,
    output logic signed [DATA_W-1:0] dout_b
);

    localparam int DEPTH = N_POINTS / 4 + 1;

    logic signed [DATA_W-1:0] tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        assign tbl[i] = DATA_W'(quarter_entry(i, N_POINTS, DATA_W));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            dout_a <= tbl[addr_a];
            dout_b <= tbl[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_stream.sv
// Streams twiddle factors W_N^k = cos - j*sin for k = j<<s, j = 0..N/2^(s+1)-1,
// through a 2-stage pipeline (quadrant decode + table read, then negate/extend).
module twiddle_stream
    import twiddle_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [log2_int(N_POINTS)-1:0] stride_log2,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              re_out,
    output logic [OUT_W-1:0]              im_out,
    output logic [log2_int(N_POINTS)-1:0] k_out,
    output logic                          last
);

    localparam int LG    = log2_int(N_POINTS);
    localparam int AW    = LG - 1;
    localparam int QUART = N_POINTS / 4;

    state_t          state, state_n;
    logic [LG-1:0]   j, j_n, s, s_n, lastj, lastj_n;
    logic            issue, issue_last, stall;
    int              cnt;

    logic [LG-1:0]   k_iss;
    logic [1:0]      q_iss;
    logic [AW-1:0]   r_a, rp_a, cos_addr, sin_addr;
    logic signed [DATA_W-1:0] cos_rd, sin_rd;

    logic [1:0]      vld_pipe;
    logic [LG-1:0]   s1_k;
    logic [1:0]      s1_q;
    logic            s1_last;
    logic signed [OUT_W-1:0] cos_x, sin_x, re_n, im_n;

    assign out_valid = vld_pipe[1];
    assign stall     = vld_pipe[1] & ~out_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_n    = state;
        j_n        = j;
        s_n        = s;
        lastj_n    = lastj;
        issue      = 1'b0;
        issue_last = 1'b0;
        cnt        = N_POINTS >> (int'(stride_log2) + 1);
        if (cnt == 0) cnt = 1;
        case (state)
            IDLE: if (start) begin
                s_n     = stride_log2;
                j_n     = '0;
                lastj_n = LG'(cnt - 1);
                state_n = RUN;
            end
            RUN: if (!stall) begin
                issue      = 1'b1;
                issue_last = (j == lastj);
                j_n        = j + LG'(1);
                if (j == lastj) state_n = DRAIN;
            end
            DRAIN: if (out_valid && out_ready && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            j     <= '0;
            s     <= '0;
            lastj <= '0;
        end else begin
            state <= state_n;
            j     <= j_n;
            s     <= s_n;
            lastj <= lastj_n;
        end
    end

    // Odd quadrants swap the roles of r and N/4-r.
    assign k_iss    = j << s;
    assign q_iss    = k_iss[LG-1:LG-2];
    assign r_a      = {1'b0, k_iss[LG-3:0]};
    assign rp_a     = AW'(QUART) - r_a;
    assign cos_addr = q_iss[0] ? rp_a : r_a;
    assign sin_addr = q_iss[0] ? r_a  : rp_a;

    twiddle_quarter_rom #(
        .N_POINTS (N_POINTS),
        .DATA_W   (DATA_W),
        .AW       (AW)
    ) u_rom (
        .clk    (clk),
        .en     (~stall),
        .addr_a (cos_addr),
        .addr_b (sin_addr),
        .dout_a (cos_rd),
        .dout_b (sin_rd)
    );

    // cos is negative in q1,q2; sin positive in q0,q1 so im = -sin flips there.
    assign cos_x = OUT_W'(cos_rd);
    assign sin_x = OUT_W'(sin_rd);
    assign re_n  = (s1_q[1] ^ s1_q[0]) ? -cos_x : cos_x;
    assign im_n  = s1_q[1] ? sin_x : -sin_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_k     <= '0;
            s1_q     <= '0;
            s1_last  <= 1'b0;
            re_out   <= '0;
            im_out   <= '0;
            k_out    <= '0;
            last     <= 1'b0;
        end else if (!stall) begin
            vld_pipe[0] <= issue;
            s1_k        <= k_iss;
            s1_q        <= q_iss;
            s1_last     <= issue_last;
            vld_pipe[1] <= vld_pipe[0];
            last        <= vld_pipe[0] & s1_last;
            if (vld_pipe[0]) begin
                re_out <= re_n;
                im_out <= im_n;
                k_out  <= s1_k;
            end
        end
    end

endmodule

// File: doc/twiddle_stream.md
TWIDDLE_STREAM -- requirements
Module: twiddle_stream

Interface
REQ-001 SHALL have parameter N_POINTS, default 16: FFT length, power of two, 8..1024.
REQ-002 SHALL have parameter DATA_W, default 8: signed magnitude width of stored samples, 4..16.
REQ-003 SHALL have parameter OUT_W, default 16: output word width; OUT_W >= DATA_W.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a twiddle burst.
REQ-007 SHALL have port stride_log2, input, log2(N_POINTS): log2 of the index stride, sampled with start.
REQ-008 SHALL have port busy, output, 1: high from accepted start until the last word is consumed.
REQ-009 SHALL have port out_valid, output, 1: the output word is valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-011 SHALL have port re_out, output, OUT_W: cos(2*pi*k/N), two's complement, sign-extended.
REQ-012 SHALL have port im_out, output, OUT_W: -sin(2*pi*k/N), two's complement, sign-extended.
REQ-013 SHALL have port k_out, output, log2(N_POINTS): twiddle index of the current word.
REQ-014 SHALL have port last, output, 1: high with the final word of a burst.

Function
REQ-015 SHALL store only the quarter table T[i] for i = 0..N/4, where T[i] = round-half-away(A*cos(2*pi*i/N)) and A = 2^(DATA_W-1)-1.
REQ-016 SHALL split k as q = k[MSB:MSB-1] and r = remaining bits, with r' = N/4 - r.
REQ-017 SHALL map each quadrant as follows: q0: cos=T[r], sin=T[r']; q1: cos=-T[r'], sin=T[r]; q2: cos=-T[r], sin=-T[r']; q3: cos=T[r'], sin=-T[r].
REQ-018 SHALL rely on |T| <= A, so negation never overflows, and no saturation logic is present.
REQ-019 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-020 SHALL, in IDLE, accept start: capture s = stride_log2, set j = 0, set count = N >> (s+1) (minimum 1), and enter RUN.
REQ-021 SHALL, in RUN, issue k = j << s into the pipeline on every cycle the pipeline is not stalled, and enter DRAIN after issuing j = count-1.
REQ-022 SHALL, in DRAIN, return to IDLE and drop busy in the cycle the word with last=1 is accepted (out_valid & out_ready).
REQ-023 SHALL ignore start whenever busy is high.
REQ-024 SHALL use a 2-stage pipeline: stage 1 performs quadrant decode and the registered table read; stage 2 performs negation and sign extension into the output register.
REQ-025 SHALL give a latency of 2: with start high at edge 0, the first out_valid is high after edge 2.
REQ-026 SHALL sustain a throughput of one word per cycle while out_ready is high.
REQ-027 SHALL hold all stages and keep re_out, im_out, k_out and last stable while out_valid=1 and out_ready=0; no word is lost or duplicated.
REQ-028 SHALL never assert last without out_valid.
REQ-029 SHALL hold re_out, im_out and k_out at their last values while out_valid=0.

Reset
REQ-030 SHALL, while reset is high, force the FSM to IDLE and clear busy, out_valid, last, re_out, im_out, k_out and all pipeline valid bits at the next edge.
REQ-031 SHALL abort any burst in progress on reset with no further words emitted, and SHALL accept a start in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place in package twiddle_pkg: the elaboration-time quarter-table generator function, the rounding rule, the FSM state enum, and a helper computing log2 of N_POINTS.
REQ-033 SHALL instantiate one sub-module, twiddle_quarter_rom: (N/4+1)-entry, DATA_W-wide, synchronous read with clock enable (enable = not stalled).

Verification
REQ-034 SHALL cover: N=16, DATA_W=8, start with s=0, out_ready=1 -> 8 words, k=0..7, last on k=7; re = 0x007F,0x0075,0x005A,0x0031,0x0000,0xFFCF,0xFFA6,0xFF8B.
REQ-035 SHALL cover: s=0 burst check at k=4 -> re=0x0000, im=0xFF81; at k=6 -> re=0xFFA6, im=0xFFA6.
REQ-036 SHALL cover: s=2 -> exactly 2 words, k=0 then k=4 with last=1; busy low the cycle after acceptance.
REQ-037 SHALL cover: out_ready low for 3 cycles while the 3rd word (k=2) is valid -> word held stable, then k=2..7 delivered in order, 8 words total.
REQ-038 SHALL cover: start pulsed during a burst -> ignored; reset asserted after the 4th word -> outputs cleared next edge, no further valid words; a new start right after reset runs a full burst.
REQ-039 SHALL cover: N=1024, DATA_W=16 sweep, s=0 -> every word within 1 LSB of a real-valued reference for all k.
